// File: rtl/present_dec80_iter.sv
// Iterative PRESENT-80 decryptor: forward key schedule to the last round key, then ROUNDS inverse rounds.
// Optional last-key cache enabled by defining PRESENT_DEC_KEY_CACHE_EN.
module present_dec80_iter #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_ct,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pt,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

    localparam logic [4:0] LastRound = 5'(ROUNDS);

    state_t      state_q;
    logic [63:0] st_q;
    logic [79:0] key_q;
    logic [4:0]  ctr_q;
    logic        inReady_q;
    logic        outValid_q;
    logic        busy_q;
    logic [63:0] outPt_q;

`ifdef PRESENT_DEC_KEY_CACHE_EN
    logic [79:0] lastKey_q;
    logic [79:0] lastKEnd_q;
    logic        cacheVld_q;
`endif

    logic [79:0] kRot;
    logic [79:0] kFwd_d;
    logic [79:0] kUndo;
    logic [79:0] kInv_d;
    logic [63:0] stDec_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
            4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
            4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
            4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] invSbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
            4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
            4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
            4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Output bit j gathers input bit 16*j mod 63, undoing the forward layer's scatter.
    function automatic logic [63:0] invPLayer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) begin
            y[j] = x[(16 * j) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] invSLayer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = invSbox(x[4*i +: 4]);
        end
        return y;
    endfunction

    always_comb begin
        kRot           = {key_q[18:0], key_q[79:19]};
        kFwd_d         = kRot;
        kFwd_d[79:76]  = sbox(kRot[79:76]);
        kFwd_d[19:15]  = kRot[19:15] ^ ctr_q;

        kUndo          = key_q;
        kUndo[19:15]   = key_q[19:15] ^ ctr_q;
        kUndo[79:76]   = invSbox(key_q[79:76]);
        kInv_d         = {kUndo[60:0], kUndo[79:61]};

        stDec_d        = invSLayer(invPLayer(st_q)) ^ kInv_d[79:16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            st_q       <= '0;
            key_q      <= '0;
            ctr_q      <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            outPt_q    <= '0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            lastKey_q  <= '0;
            lastKEnd_q <= '0;
            cacheVld_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && inReady_q) begin
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                        if (cacheVld_q && (in_key == lastKey_q)) begin
                            st_q    <= in_ct ^ lastKEnd_q[79:16];
                            key_q   <= lastKEnd_q;
                            ctr_q   <= LastRound;
                            state_q <= DEC;
                        end else begin
                            // Miss: the remembered end key is stale until this schedule finishes.
                            st_q       <= in_ct;
                            key_q      <= in_key;
                            ctr_q      <= 5'd1;
                            lastKey_q  <= in_key;
                            cacheVld_q <= 1'b0;
                            state_q    <= KEYEXP;
                        end
`else
                        st_q    <= in_ct;
                        key_q   <= in_key;
                        ctr_q   <= 5'd1;
                        state_q <= KEYEXP;
`endif
                    end
                end
                KEYEXP: begin
                    key_q <= kFwd_d;
                    if (ctr_q == LastRound) begin
                        st_q    <= st_q ^ kFwd_d[79:16];
                        state_q <= DEC;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                        lastKEnd_q <= kFwd_d;
                        cacheVld_q <= 1'b1;
`endif
                    end else begin
                        ctr_q <= ctr_q + 5'd1;
                    end
                end
                DEC: begin
                    st_q  <= stDec_d;
                    key_q <= kInv_d;
                    ctr_q <= ctr_q - 5'd1;
                    if (ctr_q == 5'd1) begin
                        state_q    <= DONE;
                        outPt_q    <= stDec_d;
                        outValid_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_pt    = outPt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_present_dec80_iter.sv
// Scoreboard bench for present_dec80_iter using the standard PRESENT-80 vectors, back-pressure,
// in_valid flooding, a mid-block reset and (when PRESENT_DEC_KEY_CACHE_EN is defined) cache-hit latency.
module tb_present_dec80_iter;

    typedef struct {
        logic [63:0] pt;
        int          lat;
        int          xferCycle;
    } exp_t;

`ifdef PRESENT_DEC_KEY_CACHE_EN
    localparam int HitLat = 31;
`else
    localparam int HitLat = 62;
`endif
    localparam int MissLat = 62;
    localparam logic [79:0] KeyZero = 80'h0;
    localparam logic [79:0] KeyOnes = {80{1'b1}};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_ct;
    logic [79:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pt;
    logic        busy;

    int   cycle;
    int   xferCount;
    int   checkCount;
    int   passCount;
    exp_t sbQ[$];

    present_dec80_iter #(.ROUNDS(31)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ct    (in_ct),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pt   (out_pt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index and accepted-request count, both read at negedges.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst_n && in_valid && in_ready) xferCount <= xferCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [79:0] actual, input logic [79:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Offer one request and record its expected plaintext and latency in the scoreboard.
    task automatic applyStimulus(input logic [63:0] ct, input logic [79:0] key, input logic [63:0] pt,
                                 input int lat, input bit keepValid, input bit push);
        int   waitCnt;
        exp_t e;
        waitCnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ct    = ct;
        in_key   = key;
        while (in_ready !== 1'b1 && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("xfer_timeout", 80'd0, 80'd1);
            in_valid = 1'b0;
            return;
        end
        e.pt        = pt;
        e.lat       = lat;
        e.xferCycle = cycle + 1;
        @(negedge clk);
        in_valid = keepValid;
        in_ct    = '0;
        in_key   = '0;
        checkOutput("busy_after_xfer", 80'(busy), 80'd1);
        checkOutput("ready_after_xfer", 80'(in_ready), 80'd0);
        if (push) sbQ.push_back(e);
    endtask

    task automatic collectOutput(input int holdCycles);
        int          waitCnt;
        exp_t        e;
        logic [63:0] held;
        bit          stable;
        waitCnt = 0;
        stable  = 1'b1;
        while (out_valid !== 1'b1 && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (out_valid !== 1'b1 || sbQ.size() == 0) begin
            checkOutput("out_timeout", 80'd0, 80'd1);
            if (sbQ.size() != 0) void'(sbQ.pop_front());
            return;
        end
        e = sbQ.pop_front();
        checkOutput("pt", 80'(out_pt), 80'(e.pt));
        checkOutput("latency", 80'(cycle - e.xferCycle), 80'(e.lat));
        held = out_pt;
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_pt !== held || in_ready !== 1'b0) stable = 1'b0;
        end
        if (holdCycles > 0) checkOutput("hold_stable", 80'(stable), 80'd1);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("valid_after_out", 80'(out_valid), 80'd0);
        checkOutput("ready_after_out", 80'(in_ready), 80'd1);
    endtask

    initial begin
        int xferBefore;
        cycle      = 0;
        xferCount  = 0;
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_ct      = '0;
        in_key     = '0;
        out_ready  = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 80'(in_ready), 80'd1);
        checkOutput("rst_out_valid", 80'(out_valid), 80'd0);
        checkOutput("rst_busy", 80'(busy), 80'd0);
        checkOutput("rst_out_pt", 80'(out_pt), 80'd0);
        rst_n = 1'b1;

        applyStimulus(64'h5579C1387B228445, KeyZero, 64'h0, MissLat, 1'b0, 1'b1);
        collectOutput(0);
        applyStimulus(64'hE72C46C0F5945049, KeyOnes, 64'h0, MissLat, 1'b0, 1'b1);
        collectOutput(0);

        // Back-pressure with in_valid flooded for the whole block.
        xferBefore = xferCount;
        out_ready  = 1'b0;
        applyStimulus(64'hA112FFC72F68417B, KeyZero, 64'hFFFFFFFFFFFFFFFF, MissLat, 1'b1, 1'b1);
        collectOutput(10);
        @(negedge clk);
        checkOutput("one_xfer_per_block", 80'(xferCount - xferBefore), 80'd1);

        applyStimulus(64'h3333DCD3213210D2, KeyOnes, 64'hFFFFFFFFFFFFFFFF, MissLat, 1'b0, 1'b1);
        collectOutput(0);
        applyStimulus(64'h3333DCD3213210D2, KeyOnes, 64'hFFFFFFFFFFFFFFFF, HitLat, 1'b0, 1'b1);
        collectOutput(0);
        applyStimulus(64'h5579C1387B228445, KeyZero, 64'h0, MissLat, 1'b0, 1'b1);
        collectOutput(0);

        // Abort a block partway through; its result must never appear.
        applyStimulus(64'h5579C1387B228445, KeyZero, 64'h0, MissLat, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 80'(out_valid), 80'd0);
        checkOutput("abort_in_ready", 80'(in_ready), 80'd1);
        checkOutput("abort_busy", 80'(busy), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(64'hA112FFC72F68417B, KeyZero, 64'hFFFFFFFFFFFFFFFF, MissLat, 1'b0, 1'b1);
        collectOutput(0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
